cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Complete-stage scheduler between execute FUs and the N-wide CDB.
//  - Single-cycle FUs (ALU, branch) have no result buffer. They must complete in their issue cycle.
//  - Multi-cycle FUs (mult, ldst) hold their result until granted.
//  - Grants CDB slots each cycle: round-robin among multi-cycle FUs, with age-based starvation reservation.
//  - Publishes a registered single-cycle issue budget that issue honours next cycle.
// PARAMETERS
//  CDB_WIDTH     default `N               CDB slots per cycle
//  NUM_SC        default 4                single-cycle requesters (ALU + branch); request index 0..NUM_SC-1
//  NUM_MC        default 3                multi-cycle requesters (mult + ldst); request index NUM_SC..NUM_SC+NUM_MC-1
//  STARVE_LIMIT  default 4                consecutive lost cycles before a multi-cycle FU is starved
//  TOTAL         = NUM_SC+NUM_MC          local parameter
// PORTS
//  clock             in   1                    system clock
//  reset             in   1                    asynchronous, active-low reset
//  sc_req            in   NUM_SC               single-cycle FU issuing this cycle
//  mc_req            in   NUM_MC               multi-cycle FU holding a valid result (mult_cdb_valid/ldst_cdb_valid)
//  mc_squash         in   NUM_MC               FU result squashed by mispredict this cycle
//  complete_gnt_bus  out  CDB_WIDTH x TOTAL    per-slot one-hot grant, or all-zero if slot idle
//  mc_gnt            out  NUM_MC               multi-cycle FU granted; drives mult_cdb_en/ldst_cdb_en
//  sc_budget         out  $clog2(CDB_WIDTH+1)  max popcount(sc_req) issue may present next cycle (registered)
//  sc_overflow       out  1                    combinational: popcount(sc_req) > sc_budget this cycle
// BEHAVIOUR
//  - Grants are combinational from requests and registered state. All state updates on posedge clock.
//  - Masking: effective_mc = mc_req & ~mc_squash. Squashed FUs are never granted.
//  - Slot fill order each cycle:
//    (1) sc_req bits in ascending index order, capped at sc_budget.
//        Excess (highest indices) are dropped and sc_overflow=1.
//    (2) starved MC FUs (age==STARVE_LIMIT), scanned from rr_ptr upward, mod NUM_MC.
//    (3) remaining effective_mc FUs, scanned from rr_ptr upward.
//  - Slots fill 0,1,2..; unfilled slots output all-zero. Each requester appears in at most one slot.
//  - mc_gnt[i] = OR over slots of complete_gnt_bus[s][NUM_SC+i].
//  - age[i] (width $clog2(STARVE_LIMIT+1)) update:
//    - next = 0 if granted, not requesting, or squashed.
//    - else next = min(age+1, STARVE_LIMIT).
//  - rr_ptr (width $clog2(NUM_MC)): next = (highest-scan-order granted MC index + 1) mod NUM_MC.
//    Unchanged if no MC FU granted. Wrap NUM_MC-1 -> 0.
//  - sc_budget next = CDB_WIDTH - min(CDB_WIDTH, R).
//    - R = count of FUs whose next age == STARVE_LIMIT and that remain requesting (mc_req & ~mc_gnt & ~mc_squash).
//    - This guarantees starved FUs a slot next cycle.
//  - Starved FUs exceeding CDB_WIDTH are served in scan order from rr_ptr; rest keep age saturated.
//  - Simultaneous grant and squash of one FU is impossible: squash masks first.
//  - Reset (async, reset==0), all outputs/state to these values mid-operation; in-flight requests are ignored:
//    - rr_ptr=0, all age=0, sc_budget=CDB_WIDTH.
//    - complete_gnt_bus=0, mc_gnt=0, sc_overflow=0 while reset is low.
//  - Latency: grant same cycle as request. Budget effective one cycle after computation.
// CONFIGURATION
//  CDB_ARB_STARVE_EN defined:
//    - age counters, starved tier (2) and budget reservation active as above.
//  CDB_ARB_STARVE_EN undefined:
//    - no age state; tier (2) removed; sc_budget constant CDB_WIDTH.
//    - MC FUs may starve indefinitely under full SC load.
// TESTING  (CDB_WIDTH=3, NUM_SC=4, NUM_MC=3, STARVE_LIMIT=4)
//  1. Reset low mid-traffic.
//     -> All grants 0, sc_budget=3. After release, mc_req=3'b111 grants MC0,MC1,MC2 in slots 0-2; rr_ptr->0.
//  2. sc_req=4'b0111, mc_req=3'b001, STARVE_EN defined.
//     -> Slots SC0,SC1,SC2; MC0 age 1,2,3,4.
//     -> sc_budget drops to 2 after age 4 is reached. Next cycle slots SC0,SC1,MC0; MC0 age ->0; budget back to 3.
//  3. Same stimulus, STARVE_EN undefined.
//     -> MC0 never granted over 20 cycles; sc_budget stays 3.
//  4. sc_req=4'b1111 with sc_budget=3.
//     -> SC0-SC2 granted, SC3 dropped, sc_overflow=1.
//  5. rr_ptr=2, mc_req=3'b111, sc_req=4'b0011.
//     -> Slot2=MC2; rr_ptr->0. Next cycle same stimulus -> slot2=MC0; rr_ptr->1.
//  6. mc_req=3'b010, mc_squash=3'b010 while MC1 age=3.
//     -> No grant to MC1; age ->0; sc_budget remains 3.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - complete-stage CDB slot arbiter for single- and multi-cycle FUs
// Starvation protection (age counters, starved tier, budget reservation) enabled by CDB_ARB_STARVE_EN.
module cdb_arbiter #(
    parameter int CDB_WIDTH    = 3,
    parameter int NUM_SC       = 4,
    parameter int NUM_MC       = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_SC-1:0]                    sc_req,
    input  logic [NUM_MC-1:0]                    mc_req,
    input  logic [NUM_MC-1:0]                    mc_squash,
    output logic [CDB_WIDTH*(NUM_SC+NUM_MC)-1:0] complete_gnt_bus,
    output logic [NUM_MC-1:0]                    mc_gnt,
    output logic [$clog2(CDB_WIDTH+1)-1:0]       sc_budget,
    output logic                                 sc_overflow
);
    localparam int TOTAL = NUM_SC + NUM_MC;
    localparam int BW    = $clog2(CDB_WIDTH + 1);
    localparam int RR_W  = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

    logic [RR_W-1:0]            rr_q, rr_d;
    logic [NUM_MC-1:0]          eff_mc;
    logic [CDB_WIDTH*TOTAL-1:0] gnt_bus;
    logic [NUM_MC-1:0]          gnt_mc;
    logic                       overflow;
    logic [BW-1:0]              budget;
    logic                       any_mc;
    int                         slot;
    int                         last_off;
    int                         idx;

`ifdef CDB_ARB_STARVE_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    logic [NUM_MC-1:0][AGE_W-1:0] age_q, age_d;
    logic [BW-1:0]                sc_budget_q, sc_budget_d;
    int                           r_cnt;
    assign budget = sc_budget_q;
`else
    assign budget = BW'(CDB_WIDTH);
`endif

    assign eff_mc = mc_req & ~mc_squash;

    // Tiers fill slots in order: capped SC, starved MC, remaining MC.
    always_comb begin
        gnt_bus  = '0;
        gnt_mc   = '0;
        overflow = 1'b0;
        any_mc   = 1'b0;
        slot     = 0;
        last_off = 0;
        idx      = 0;
        for (int i = 0; i < NUM_SC; i++) begin
            if (sc_req[i]) begin
                if (slot < int'(budget) && slot < CDB_WIDTH) begin
                    gnt_bus[slot*TOTAL + i] = 1'b1;
                    slot = slot + 1;
                end else begin
                    overflow = 1'b1;
                end
            end
        end
`ifdef CDB_ARB_STARVE_EN
        for (int k = 0; k < NUM_MC; k++) begin
            idx = (int'(rr_q) + k) % NUM_MC;
            if (eff_mc[idx] && age_q[idx] == AGE_W'(STARVE_LIMIT) && slot < CDB_WIDTH) begin
                gnt_bus[slot*TOTAL + NUM_SC + idx] = 1'b1;
                gnt_mc[idx] = 1'b1;
                slot        = slot + 1;
                any_mc      = 1'b1;
                if (k > last_off) last_off = k;
            end
        end
`endif
        for (int k = 0; k < NUM_MC; k++) begin
            idx = (int'(rr_q) + k) % NUM_MC;
            if (eff_mc[idx] && !gnt_mc[idx] && slot < CDB_WIDTH) begin
                gnt_bus[slot*TOTAL + NUM_SC + idx] = 1'b1;
                gnt_mc[idx] = 1'b1;
                slot        = slot + 1;
                any_mc      = 1'b1;
                if (k > last_off) last_off = k;
            end
        end
        // Pointer moves past the furthest-in-scan-order granted FU.
        rr_d = any_mc ? RR_W'((int'(rr_q) + last_off + 1) % NUM_MC) : rr_q;
    end

`ifdef CDB_ARB_STARVE_EN
    always_comb begin
        age_d = '0;
        r_cnt = 0;
        for (int i = 0; i < NUM_MC; i++) begin
            if (gnt_mc[i] || !mc_req[i] || mc_squash[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] == AGE_W'(STARVE_LIMIT)) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + 1'b1;
            end
            if (age_d[i] == AGE_W'(STARVE_LIMIT)) r_cnt = r_cnt + 1;
        end
        // Reserve one slot per FU that will be starved and still waiting next cycle.
        sc_budget_d = BW'(CDB_WIDTH - ((r_cnt < CDB_WIDTH) ? r_cnt : CDB_WIDTH));
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q        <= '0;
`ifdef CDB_ARB_STARVE_EN
            age_q       <= '0;
            sc_budget_q <= BW'(CDB_WIDTH);
`endif
        end else begin
            rr_q        <= rr_d;
`ifdef CDB_ARB_STARVE_EN
            age_q       <= age_d;
            sc_budget_q <= sc_budget_d;
`endif
        end
    end

    assign complete_gnt_bus = reset ? gnt_bus : '0;
    assign mc_gnt           = reset ? gnt_mc : '0;
    assign sc_overflow      = reset & overflow;
    assign sc_budget        = budget;

endmodule
